dram_cache_wr_arbiter: RTL

Round-robin arbiter that shares the single DRAM-cache write/fill channel among NUM_REQ requesters: read-miss fill (index 0), write-hit/write-allocate path (index 1) and writeback/refill path (index 2). It sits between those handlers and the DRAM-cache data/tag write stage. Each beat it selects one valid request, registers the {addr, data} payload and the source index in a one-entry output buffer, and presents it downstream with a valid/ready handshake. Throughput is one beat per cycle while downstream accepts.

---
 rtl/dram_cache_wr_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dram_cache_wr_arbiter.sv
// Round-robin arbiter sharing the DRAM-cache write/fill channel among
// NUM_REQ requesters, with a one-entry registered output buffer.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

module dram_cache_wr_arbiter #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned ADDR_WIDTH  = `AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = `AXI_DATA_WIDTH,
  parameter int unsigned WDATA_WIDTH = ADDR_WIDTH + DATA_WIDTH,
  parameter int unsigned SRC_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*WDATA_WIDTH-1:0] req_wdata_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [WDATA_WIDTH-1:0]       wdata_o,
  output logic [SRC_WIDTH-1:0]         src_o
);

  // One spare bit so ptr + offset never overflows before the wrap subtract.
  localparam int unsigned IDX_W = SRC_WIDTH + 1;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  // Elaboration-time parameter sanity.
  if (WDATA_WIDTH != ADDR_WIDTH + DATA_WIDTH) begin : g_bad_wdata_width
    $error("WDATA_WIDTH must equal ADDR_WIDTH + DATA_WIDTH");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end

  logic [0:0]             state, state_nxt;
  logic [SRC_WIDTH-1:0]   ptr, ptr_nxt;
  logic [WDATA_WIDTH-1:0] wdata_nxt;
  logic [SRC_WIDTH-1:0]   src_nxt;
  logic [SRC_WIDTH-1:0]   grant;
  logic                   grant_valid;
  logic                   load_en;
  logic [WDATA_WIDTH-1:0] wdata_sel;
  logic [IDX_W-1:0]       idx;

  // Rotating priority scan starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'(ptr) + IDX_W'(k);
      if (idx >= IDX_W'(NUM_REQ)) begin
        idx = idx - IDX_W'(NUM_REQ);
      end
      if (!grant_valid && req_valid_i[idx[SRC_WIDTH-1:0]]) begin
        grant_valid = 1'b1;
        grant       = idx[SRC_WIDTH-1:0];
      end
    end
  end

  // Payload mux for the granted requester.
  always_comb begin
    wdata_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant == SRC_WIDTH'(i)) begin
        wdata_sel = req_wdata_i[i*WDATA_WIDTH +: WDATA_WIDTH];
      end
    end
  end

  // Buffer can take a new beat when empty or when draining this cycle.
  assign load_en = (state == EMPTY) || ready_i;

  // Per-requester accept, one-hot at most; silenced during reset.
  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = rst_n && load_en && grant_valid && (grant == SRC_WIDTH'(i));
    end
  end

  // Next-state for buffer occupancy, payload, source and priority pointer.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wdata_nxt = wdata_o;
    src_nxt   = src_o;
    if (load_en) begin
      if (grant_valid) begin
        state_nxt = FULL;
        wdata_nxt = wdata_sel;
        src_nxt   = grant;
        ptr_nxt   = (grant == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : grant + SRC_WIDTH'(1);
      end else begin
        state_nxt = EMPTY;
      end
    end
  end

  // Registered state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ptr     <= '0;
      wdata_o <= '0;
      src_o   <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      wdata_o <= wdata_nxt;
      src_o   <= src_nxt;
    end
  end

  assign valid_o = (state == FULL);

endmodule
